// File: rtl/neighbor_fifo_reader.sv
// neighbor_fifo_reader: read side of the neighbour-info sync FIFO feeding a 2-entry skid buffer,
// with a flush mode that drains and discards FIFO contents, plus saturating delivery/drop counters.
module neighbor_fifo_reader #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              wclk,
  input  logic              rst,
  input  logic              fifo_rempty,
  output logic              fifo_rinc,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              busy,
  output logic [CNT_W-1:0]  deliver_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t r_state, w_state_nxt;
  logic r_pend;
  logic [1:0] r_occ;
  logic r_rptr, r_wptr;
  logic [DATA_W-1:0] r_mem [2];
  logic [CNT_W-1:0] r_deliver_cnt, r_drop_cnt;
  logic w_pop, w_push, w_flush_go, w_discard;
  logic [2:0] w_room;
  logic [1:0] w_occ_nxt, w_drop_add;
  logic [CNT_W:0] w_dlv_sum, w_drop_sum;

  assign out_valid   = (r_state != FLUSH) && (r_occ != 2'd0);
  assign out_data    = r_mem[r_rptr];
  assign w_pop       = out_valid && out_ready;
  assign w_flush_go  = flush_req && (r_state != FLUSH);
  // an entry arriving on the flush-entry edge or during FLUSH is dropped, never buffered
  assign w_discard   = w_flush_go || (r_state == FLUSH);
  assign w_push      = r_pend && !w_discard;
  assign w_room      = {1'b0, r_occ} + {2'b0, r_pend} - {2'b0, w_pop};
  assign fifo_rinc   = rst && !fifo_rempty &&
                       ((r_state == FLUSH) || (!flush_req && (w_room < 3'd2)));
  assign w_occ_nxt   = w_flush_go ? 2'd0 : r_occ + {1'b0, w_push} - {1'b0, w_pop};
  assign w_drop_add  = w_flush_go ? r_occ + {1'b0, r_pend} - {1'b0, w_pop}
                                  : ((r_state == FLUSH) ? {1'b0, r_pend} : 2'd0);
  assign w_dlv_sum   = {1'b0, r_deliver_cnt} + {{CNT_W{1'b0}}, w_pop};
  assign w_drop_sum  = {1'b0, r_drop_cnt} + {{(CNT_W-1){1'b0}}, w_drop_add};
  assign busy        = (r_state != IDLE) || (r_occ != 2'd0) || r_pend;
  assign deliver_cnt = r_deliver_cnt;
  assign drop_cnt    = r_drop_cnt;

  always_comb begin
    w_state_nxt = r_state;
    flush_done  = 1'b0;
    case (r_state)
      IDLE:  w_state_nxt = flush_req ? FLUSH : (!fifo_rempty ? RUN : IDLE);
      RUN:   w_state_nxt = flush_req ? FLUSH :
                           ((fifo_rempty && !r_pend && r_occ == 2'd0) ? IDLE : RUN);
      FLUSH: begin
        flush_done  = fifo_rempty && !r_pend;
        w_state_nxt = flush_done ? IDLE : FLUSH;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_pend        <= 1'b0;
      r_occ         <= 2'd0;
      r_rptr        <= 1'b0;
      r_wptr        <= 1'b0;
      r_mem[0]      <= '0;
      r_mem[1]      <= '0;
      r_deliver_cnt <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pend        <= fifo_rinc;
      r_occ         <= w_occ_nxt;
      r_deliver_cnt <= w_dlv_sum[CNT_W] ? '1 : w_dlv_sum[CNT_W-1:0];
      r_drop_cnt    <= w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];
      if (w_push) r_mem[r_wptr] <= fifo_rdata;
      if (w_flush_go) begin
        r_rptr <= 1'b0;
        r_wptr <= 1'b0;
      end else begin
        r_rptr <= r_rptr ^ w_pop;
        r_wptr <= r_wptr ^ w_push;
      end
    end
  end
endmodule

// File: tb/tb_neighbor_fifo_reader.sv
// tb_neighbor_fifo_reader: scoreboard bench around a behavioural sync-FIFO model
// with registered read data; expected entries are queued at load time and popped on handoff.
module tb_neighbor_fifo_reader;
  localparam int DW = 64, CW = 16;
  logic wclk = 1'b0, rst = 1'b1;
  logic fifo_rempty = 1'b1, fifo_rinc, out_valid, out_ready = 1'b0;
  logic flush_req = 1'b0, flush_done, busy;
  logic [DW-1:0] fifo_rdata = '0, out_data;
  logic [CW-1:0] deliver_cnt, drop_cnt;
  logic [DW-1:0] fq[$], exp_q[$];
  int checks = 0, errors = 0, cyc = 0, strobes = 0, fdones = 0, streak = 0, last_pop = -10;
  int exp_drop = 0, s0 = 0, f0 = 0, n = 0;

  neighbor_fifo_reader #(.DATA_W(DW), .CNT_W(CW)) dut (
    .wclk(wclk), .rst(rst), .fifo_rempty(fifo_rempty), .fifo_rinc(fifo_rinc),
    .fifo_rdata(fifo_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .flush_req(flush_req), .flush_done(flush_done),
    .busy(busy), .deliver_cnt(deliver_cnt), .drop_cnt(drop_cnt)
  );

  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO model: data registered one edge after an accepted strobe, zero otherwise
  always @(posedge wclk or negedge rst) begin
    if (!rst) begin
      fq.delete();
      fifo_rempty <= 1'b1;
      fifo_rdata  <= '0;
    end else begin
      if (fifo_rinc && !fifo_rempty) fifo_rdata <= fq.pop_front();
      else fifo_rdata <= '0;
      fifo_rempty <= (fq.size() == 0);
    end
  end

  always @(negedge wclk) begin
    cyc++;
    if (fifo_rinc) begin
      strobes++;
      check("strobe_on_empty", fifo_rempty, 0);
    end
    if (flush_done) fdones++;
    if (out_valid && out_ready) begin
      check("delivery_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("out_data", out_data, exp_q.pop_front());
      streak   = (cyc == last_pop + 1) ? streak + 1 : 1;
      last_pop = cyc;
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge wclk);
    #1;
  endtask

  task automatic load(input logic [DW-1:0] base, input int k);
    for (int i = 0; i < k; i++) begin
      fq.push_back(base + DW'(i));
      exp_q.push_back(base + DW'(i));
    end
  endtask

  task automatic drain(input string tag, input int max);
    int c = 0;
    while (exp_q.size() != 0 && c < max) begin
      @(negedge wclk);
      c++;
    end
    check(tag, 64'(exp_q.size()), 0);
  endtask

  task automatic wait_flush_done(input string tag);
    int c = 0;
    while (fdones == f0 && c < 40) begin
      @(negedge wclk);
      c++;
    end
    check(tag, 64'(fdones - f0), 1);
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_done", flush_done, 0);
    check("rst_busy", busy, 0);
    check("rst_rinc", fifo_rinc, 0);
    check("rst_deliver", deliver_cnt, 0);
    check("rst_drop", drop_cnt, 0);
    tick(2);
    rst = 1'b1;
    tick(2);
    // basic stream
    out_ready = 1'b1;
    s0 = strobes;
    load(64'hA0, 4);
    drain("basic_drain", 20);
    check("basic_strobes", 64'(strobes - s0), 4);
    check("basic_streak", 64'(streak), 4);
    tick(3);
    check("basic_busy", busy, 0);
    check("basic_deliver", deliver_cnt, 4);
    // backpressure
    out_ready = 1'b0;
    s0 = strobes;
    load(64'hB0, 6);
    tick(10);
    check("bp_strobes_stalled", 64'(strobes - s0), 2);
    check("bp_valid", out_valid, 1);
    check("bp_head", out_data, 64'hB0);
    out_ready = 1'b1;
    drain("bp_drain", 30);
    check("bp_streak", 64'(streak), 6);
    check("bp_strobes_total", 64'(strobes - s0), 6);
    tick(3);
    check("bp_deliver", deliver_cnt, 10);
    // toggling ready
    s0 = strobes;
    out_ready = 1'b0;
    load(64'hC0, 8);
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
      out_ready = ~out_ready;
      tick(1);
    end
    check("tog_drain", 64'(exp_q.size()), 0);
    out_ready = 1'b1;
    tick(3);
    check("tog_strobes", 64'(strobes - s0), 8);
    check("tog_deliver", deliver_cnt, 18);
    // flush mid-stream with a full buffer
    out_ready = 1'b0;
    s0 = strobes;
    f0 = fdones;
    load(64'hD0, 8);
    tick(6);
    check("fl_valid_before", out_valid, 1);
    exp_drop += exp_q.size();
    exp_q.delete();
    flush_req = 1'b1;
    tick(1);
    flush_req = 1'b0;
    check("fl_valid_after", out_valid, 0);
    wait_flush_done("fl_done_seen");
    tick(3);
    check("fl_done_once", 64'(fdones - f0), 1);
    check("fl_drop", drop_cnt, 64'(exp_drop));
    check("fl_deliver", deliver_cnt, 18);
    check("fl_strobes", 64'(strobes - s0), 8);
    check("fl_busy", busy, 0);
    // flush while a read is in flight
    out_ready = 1'b1;
    f0 = fdones;
    load(64'hE0, 1);
    n = 0;
    while (!fifo_rinc && n < 10) begin
      @(negedge wclk);
      n++;
    end
    check("if_strobe_seen", fifo_rinc, 1);
    @(posedge wclk);
    #1;
    exp_drop += exp_q.size();
    exp_q.delete();
    flush_req = 1'b1;
    tick(1);
    flush_req = 1'b0;
    wait_flush_done("if_done_seen");
    tick(3);
    check("if_drop", drop_cnt, 64'(exp_drop));
    check("if_deliver", deliver_cnt, 18);
    // reset mid-operation with an entry buffered and a read in flight
    out_ready = 1'b0;
    load(64'hF0, 4);
    tick(3);
    check("rs_pre_valid", out_valid, 1);
    rst = 1'b0;
    #1;
    check("rs_valid", out_valid, 0);
    check("rs_rinc", fifo_rinc, 0);
    check("rs_deliver", deliver_cnt, 0);
    check("rs_drop", drop_cnt, 0);
    check("rs_busy", busy, 0);
    exp_q.delete();
    exp_drop = 0;
    tick(3);
    rst = 1'b1;
    tick(1);
    out_ready = 1'b1;
    load(64'h5A0, 3);
    drain("rs_drain", 20);
    tick(3);
    check("rs_deliver_after", deliver_cnt, 3);
    check("rs_drop_after", drop_cnt, 64'(exp_drop));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
